// File: rtl/apb_pkg.sv
// apb_pkg -- shared definitions for the two-requester APB master.
//   apb_state_e : transfer FSM states (IDLE / SETUP / ACCESS)
//   APB_ADDR_W, APB_DATA_W, APB_TIMEOUT : default parameter values
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W  = 5;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2 -- two-input round-robin arbiter with a last-grant pointer.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   req0_i, req1_i    : requests
//   grant_en_i        : high when the master can accept a new grant
//   gnt_valid_o       : at least one request is pending
//   gnt_idx_o         : index of the requester that wins (0 or 1)
// The pointer resets to requester 1 so that requester 0 wins the first tie,
// and it only moves when a grant is actually taken.
module apb_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_en_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  logic last_q;

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    // On a tie the requester not served last wins; a lone request wins outright.
    gnt_idx_o   = (req0_i & req1_i) ? ~last_q : req1_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (grant_en_i && gnt_valid_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master -- arbitrates two simple request ports onto one APB master.
//   pclk, reset                    : clock, asynchronous active-high reset
//   req*/addr*/wr*/wdata*          : requester ports (req held until ack)
//   ack0, ack1, rdata, err         : one-cycle completion; rdata/err are zero
//                                    outside ack cycles so they can be OR-ed
//   paddr/pwrite/psel/penable/pwdata : APB request (all registered)
//   prdata/pready/pslverr          : APB completer response
// A transfer stuck in ACCESS for TIMEOUT cycles is ended with err = 1.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic              owner_q;
  logic [7:0]        cnt_q;
  logic              ack0_q, ack1_q, err_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rdata_q;
  logic              gnt_valid, gnt_idx;

  apb_rr_arb2 u_arb (
    .clk_i       (pclk),
    .rst_i       (reset),
    .req0_i      (req0),
    .req1_i      (req1),
    .grant_en_i  (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      // Completion outputs are single-cycle pulses; default them low.
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q  <= gnt_idx;
            paddr_q  <= gnt_idx ? addr1  : addr0;
            pwrite_q <= gnt_idx ? wr1    : wr0;
            pwdata_q <= gnt_idx ? wdata1 : wdata0;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready wins over the timeout if both hit in the same cycle.
          if (pready || (cnt_q == TO_LAST)) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= ST_IDLE;
            ack0_q    <= ~owner_q;
            ack1_q    <= owner_q;
            if (pready) begin
              rdata_q <= pwrite_q ? '0 : prdata;
              err_q   <= pslverr;
            end else begin
              err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Testbench for apb_arb_master: a behavioural APB completer with memory, and a
// transaction-level reference model (expected memory, round-robin last-served,
// expected ack latency from wait states / timeout).
module tb_apb_arb_master;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        reset;
  logic        req0, req1, wr0, wr1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [31:0] rdata;
  logic [4:0]  paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  apb_arb_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] ref_mem [32];
  int          last_served;

  // Behavioural completer
  logic [31:0] slv_mem [32];
  int          slv_waits = 0;
  bit          slv_hang  = 1'b0;
  bit          slv_err   = 1'b0;
  int          wcnt      = 0;

  always @(negedge pclk) begin
    if (psel === 1'b1 && penable === 1'b1) begin
      if (slv_hang || wcnt < slv_waits) begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
        wcnt++;
      end else begin
        pready  = 1'b1;
        pslverr = slv_err;
        prdata  = slv_mem[paddr];
        if (pwrite && !slv_err) slv_mem[paddr] = pwdata;
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      wcnt    = 0;
    end
  end

  task automatic set_req(input int id, input bit r, input bit w,
                         input logic [4:0] a, input logic [31:0] d);
    if (id == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One single-requester transfer with every cycle checked.
  task automatic run_xfer(input int id, input bit w, input logic [4:0] a,
                          input logic [31:0] d, input int waits, input bit hang,
                          input bit serr, input bit scramble);
    int          cyc, exp_cyc;
    bit          done;
    logic [31:0] exp_rdata;
    bit          exp_err;
    exp_cyc   = hang ? (3 + TO - 1) : (3 + waits);
    exp_err   = hang ? 1'b1 : serr;
    exp_rdata = (hang || w) ? 32'h0 : ref_mem[a];
    slv_waits = waits; slv_hang = hang; slv_err = serr;
    @(negedge pclk);
    set_req(id, 1'b1, w, a, d);
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
      if (ack0 || ack1) begin
        done = 1'b1;
        set_req(id, 1'b0, 1'($urandom), 5'($urandom), $urandom);
      end else begin
        n_checks++;
        if ({psel, penable} !== {1'b1, (cyc >= 2)}) $display("FAIL phase cyc=%0d: psel/penable got %b expected %b", cyc, {psel, penable}, {1'b1, (cyc >= 2)});
        else n_pass++;
        n_checks++;
        if ({paddr, pwrite, pwdata} !== {a, w, d}) $display("FAIL req_stable cyc=%0d: got a=%h w=%b d=%h expected a=%h w=%b d=%h", cyc, paddr, pwrite, pwdata, a, w, d);
        else n_pass++;
        n_checks++;
        if ({rdata, err} !== 33'h0) $display("FAIL idle_bus cyc=%0d: rdata=%h err=%b expected 0/0", cyc, rdata, err);
        else n_pass++;
        if (cyc == 1 && scramble) set_req(id, 1'b1, 1'($urandom), 5'($urandom), $urandom);
      end
    end
    n_checks++;
    if (!done) begin
      $display("FAIL ack_bound: no ack within 40 cycles, expected at cycle %0d", exp_cyc);
      set_req(id, 1'b0, 1'b0, 5'h0, 32'h0);
    end else n_pass++;
    if (done) begin
      n_checks++;
      if (cyc != exp_cyc) $display("FAIL ack_latency: got %0d expected %0d", cyc, exp_cyc);
      else n_pass++;
      n_checks++;
      if ({ack0, ack1} !== {(id == 0), (id == 1)}) $display("FAIL ack_id: got ack0/ack1=%b expected %b", {ack0, ack1}, {(id == 0), (id == 1)});
      else n_pass++;
      n_checks++;
      if ({psel, penable} !== 2'b00) $display("FAIL ack_psel: got %b expected 00", {psel, penable});
      else n_pass++;
      n_checks++;
      if (rdata !== exp_rdata) $display("FAIL ack_rdata: got %h expected %h", rdata, exp_rdata);
      else n_pass++;
      n_checks++;
      if (err !== exp_err) $display("FAIL ack_err: got %b expected %b", err, exp_err);
      else n_pass++;
      if (w && !exp_err) ref_mem[a] = d;
      last_served = id;
    end
    $display("xfer id=%0d %s addr=%02h wdata=%08h waits=%0d hang=%0d serr=%0d -> cyc=%0d rdata=%08h err=%0d",
             id, w ? "WR" : "RD", a, d, waits, hang, serr, cyc, rdata, err);
    slv_waits = 0; slv_hang = 1'b0; slv_err = 1'b0;
    @(posedge pclk); #1;
    n_checks++;
    if ({psel, ack0, ack1, rdata, err} !== 36'h0) $display("FAIL post_idle: psel=%b ack=%b%b rdata=%h err=%b expected all 0", psel, ack0, ack1, rdata, err);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 5'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 5'h0, 32'h0);
    repeat (2) @(posedge pclk);
    #1;
    n_checks++;
    if ({psel, penable, pwrite, ack0, ack1, err} !== 6'h0) $display("FAIL reset_ctrl: got %b expected 000000", {psel, penable, pwrite, ack0, ack1, err});
    else n_pass++;
    n_checks++;
    if ({paddr, pwdata, rdata} !== 69'h0) $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h expected 0", paddr, pwdata, rdata);
    else n_pass++;
    @(negedge pclk);
    reset = 1'b0;
    last_served = 1;
    $display("reset released");
  endtask

  task automatic test_round_robin();
    int          cyc, nack, exp_id, got_id;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    a0 = 5'h04; a1 = 5'h05; d0 = $urandom; d1 = $urandom;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b1, a0, d0);
    set_req(1, 1'b1, 1'b1, a1, d1);
    cyc = 0; nack = 0;
    while (nack < 4 && cyc < 60) begin
      @(posedge pclk); #1;
      cyc++;
      n_checks++;
      if (ack0 && ack1) $display("FAIL ack_overlap cyc=%0d: both acks high", cyc);
      else n_pass++;
      if (ack0 || ack1) begin
        nack++;
        exp_id = (last_served == 0) ? 1 : 0;
        got_id = ack1 ? 1 : 0;
        n_checks++;
        if (got_id != exp_id) $display("FAIL rr_order ack#%0d: got requester %0d expected %0d", nack, got_id, exp_id);
        else n_pass++;
        n_checks++;
        if (cyc != 3 * nack || err !== 1'b0) $display("FAIL rr_timing ack#%0d: cyc=%0d err=%b expected cyc=%0d err=0", nack, cyc, err, 3 * nack);
        else n_pass++;
        ref_mem[exp_id == 0 ? a0 : a1] = (exp_id == 0) ? d0 : d1;
        last_served = exp_id;
        $display("rr ack#%0d requester=%0d cyc=%0d", nack, got_id, cyc);
        if (nack == 4) begin
          set_req(0, 1'b0, 1'b0, 5'h0, 32'h0);
          set_req(1, 1'b0, 1'b0, 5'h0, 32'h0);
        end
      end
    end
    n_checks++;
    if (nack != 4) begin
      $display("FAIL rr_bound: got %0d acks expected 4", nack);
      set_req(0, 1'b0, 1'b0, 5'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 5'h0, 32'h0);
    end else n_pass++;
    @(posedge pclk); #1;
    n_checks++;
    if (psel !== 1'b0) $display("FAIL rr_release: psel got %b expected 0", psel);
    else n_pass++;
    run_xfer(1, 1'b0, a0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(0, 1'b0, a1, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_read();
    run_xfer(0, 1'b1, 5'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(0, 1'b0, 5'h10, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_xfer(1, 1'b0, 5'h10, 32'h0, 3, 1'b0, 1'b0, 1'b1);
    run_xfer(0, 1'b1, 5'h11, 32'hCAFEF00D, 3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    run_xfer(0, 1'b0, 5'h10, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    run_xfer(1, 1'b1, 5'h12, 32'h0BADF00D, 0, 1'b1, 1'b0, 1'b0);
    run_xfer(1, 1'b0, 5'h12, 32'h0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_slverr();
    run_xfer(0, 1'b0, 5'h10, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    run_xfer(1, 1'b1, 5'h13, 32'h12345678, 0, 1'b0, 1'b1, 1'b0);
    run_xfer(1, 1'b0, 5'h13, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    slv_hang = 1'b1;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b1, 5'h03, 32'hA5A5A5A5);
    repeat (3) @(posedge pclk);
    #1;
    n_checks++;
    if ({psel, penable} !== 2'b11) $display("FAIL abort_pre: psel/penable got %b expected 11", {psel, penable});
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({psel, penable} !== 2'b00) $display("FAIL abort_async: psel/penable got %b expected 00", {psel, penable});
    else n_pass++;
    set_req(0, 1'b0, 1'b0, 5'h0, 32'h0);
    slv_hang = 1'b0;
    repeat (2) begin
      @(posedge pclk); #1;
      n_checks++;
      if ({ack0, ack1, psel} !== 3'b000) $display("FAIL abort_noack: ack0/ack1/psel got %b expected 000", {ack0, ack1, psel});
      else n_pass++;
    end
    @(negedge pclk);
    reset = 1'b0;
    last_served = 1;
    $display("reset pulsed during ACCESS");
    run_xfer(1, 1'b0, 5'h03, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(0, 1'b1, 5'h03, 32'h5A5A5A5A, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_xfer(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom), $urandom,
               int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 7) == 0), 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 32'h0;
      slv_mem[i] = 32'h0;
    end
    last_served = 1;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter ADDR_W, default 5, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced completion; legal range 2..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 pclk  in  1  the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req0, req1  in  1 each  transfer request; held high until the matching ack.
REQ-008 addr0, addr1  in  ADDR_W each  requested address.
REQ-009 wr0, wr1  in  1 each  1 = write, 0 = read.
REQ-010 wdata0, wdata1  in  DATA_W each  write data.
REQ-011 ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-012 rdata  out  DATA_W  read data; valid in the ack cycle.
REQ-013 err  out  1  transfer error; valid in the ack cycle.
REQ-014 paddr, pwrite, psel, penable, pwdata  out  ADDR_W/1/1/1/DATA_W  APB master request.
REQ-015 prdata, pready, pslverr  in  DATA_W/1/1  APB completer response.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS. All outputs SHALL be registered.
REQ-017 IDLE: if either req is high, grant one requester, latch its addr, wr and wdata into paddr, pwrite and pwdata, assert psel and go to SETUP. With no request, stay in IDLE with psel = penable = 0.
REQ-018 Arbitration: round-robin with a last-grant pointer. On simultaneous requests, grant the requester not served last. A lone request is granted immediately.
REQ-019 SETUP: psel = 1, penable = 0 for exactly one cycle, then go to ACCESS.
REQ-020 ACCESS: psel = 1, penable = 1, with paddr, pwrite and pwdata stable. On pready = 1, register rdata = prdata on reads (0 on writes) and err = pslverr, pulse ack of the granted requester, drop psel and penable, and return to IDLE.
REQ-021 Minimum transfer: request sampled in cycle N gives psel in N+1, penable in N+2 and ack in N+3 with zero wait states. The next grant is no earlier than the ack cycle.
REQ-022 Timeout: a counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready = 0. When the count reaches TIMEOUT-1 without pready, end the transfer with err = 1, rdata = 0 and ack pulsed, then return to IDLE.
REQ-023 Outside ack cycles, ack0 = ack1 = 0, rdata = 0 and err = 0 (zero-idle, OR-able read bus).
REQ-024 If req drops after grant, the transfer still completes and acks. A req change mid-transfer has no effect on the latched request.
REQ-025 ack0 and ack1 are never high in the same cycle; psel is never high without a grant.
REQ-026 The last-grant pointer updates only on grant.

Reset
REQ-027 While reset = 1, asynchronously: state = IDLE; psel, penable, pwrite, ack0, ack1 and err = 0; paddr, pwdata and rdata = 0; timeout counter = 0; last-grant = requester 1 (so requester 0 wins the first tie).
REQ-028 Reset asserted mid-transfer aborts the transfer with no ack. After release, operation starts again from IDLE.

Structure
REQ-029 Shared package apb_pkg holds the state encoding (IDLE/SETUP/ACCESS) and the default ADDR_W, DATA_W and TIMEOUT constants.
REQ-030 Sub-module apb_rr_arb2 holds the two-input round-robin grant logic and the last-grant pointer. The FSM, datapath latches and timeout counter stay in apb_arb_master.

Verification
REQ-031 Scenario: req0 writes 0xDEADBEEF to 0x10 against a zero-wait slave -> psel in N+1, penable in N+2, ack0 in N+3, err = 0; a read of 0x10 then returns rdata = 0xDEADBEEF with ack0.
REQ-032 Scenario: req0 and req1 raised together after reset and held for 4 transfers -> grant order 0,1,0,1; acks never overlap.
REQ-033 Scenario: slave inserts 3 wait states -> penable and paddr stable for 4 ACCESS cycles; ack in the cycle after pready.
REQ-034 Scenario: pready held 0 with TIMEOUT = 16 -> ack with err = 1 and rdata = 0 after 16 ACCESS cycles; the FSM returns to IDLE.
REQ-035 Scenario: read with pslverr = 1 -> err = 1 in the ack cycle; rdata = prdata.
REQ-036 Scenario: reset pulsed during ACCESS -> psel and penable = 0 at once, no ack, and the next request is served normally.
